// File: rtl/riscv_v_cmp_mask_packer_if.sv
// Handshake bundle between the vector compare datapath and the mask packer:
// operation start, compare-result beats in, packed mask out.
interface riscv_v_cmp_mask_packer_if #(
  parameter int NUM_BYTES = 16,
  parameter int MAX_ELEMS = 128
);
  logic                   start;
  logic [7:0]             vl;
  logic [3:0]             osize;
  logic                   in_valid;
  logic                   in_ready;
  logic [8*NUM_BYTES-1:0] in_result;
  logic [NUM_BYTES-1:0]   in_byte_valid;
  logic                   mask_valid;
  logic                   mask_ready;
  logic [MAX_ELEMS-1:0]   mask_data;
  logic                   busy;

  modport master (
    output start, vl, osize, in_valid, in_result, in_byte_valid, mask_ready,
    input  in_ready, mask_valid, mask_data, busy
  );

  modport slave (
    input  start, vl, osize, in_valid, in_result, in_byte_valid, mask_ready,
    output in_ready, mask_valid, mask_data, busy
  );
endinterface

// File: rtl/riscv_v_cmp_mask_packer.sv
// Packs per-element set-compare result bits from byte-wide beats into a
// dense mask (element i at bit i), with tail bits at and beyond vl held at 0.
module riscv_v_cmp_mask_packer #(
  parameter int NUM_BYTES = 16,
  parameter int MAX_ELEMS = 128
) (
  input logic                      clk,
  input logic                      rst_n,
  riscv_v_cmp_mask_packer_if.slave bus
);

  localparam int CNT_W_RAW = $clog2(MAX_ELEMS + NUM_BYTES + 1);
  localparam int CNT_W     = (CNT_W_RAW > 9) ? CNT_W_RAW : 9;
  localparam int IDX_W     = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

  state_t               state;
  logic [3:0]           osize_q;
  logic [CNT_W-1:0]     vl_q;
  logic [CNT_W-1:0]     elem_cnt;
  logic [MAX_ELEMS-1:0] mask_q;
  logic                 mask_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;

  logic [CNT_W-1:0]     vl_eff;
  logic [CNT_W-1:0]     epb;
  logic [NUM_BYTES-1:0] elem_bits;
  logic [MAX_ELEMS-1:0] mask_next;
  logic                 last_beat;

  assign vl_eff = (CNT_W'(bus.vl) > CNT_W'(MAX_ELEMS)) ? CNT_W'(MAX_ELEMS) : CNT_W'(bus.vl);

  // Compare bit of element k sits in bit 0 of its least-significant byte.
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    logic [NUM_BYTES-1:0] bits_8, bits_16, bits_32, bits_64;
    bits_8  = '0;
    bits_16 = '0;
    bits_32 = '0;
    bits_64 = '0;
    for (int k = 0; k < NUM_BYTES; k++)
      bits_8[k] = bus.in_result[8*k] & bus.in_byte_valid[k];
    for (int k = 0; k < NUM_BYTES / 2; k++)
      bits_16[k] = bus.in_result[16*k] & bus.in_byte_valid[2*k];
    for (int k = 0; k < NUM_BYTES / 4; k++)
      bits_32[k] = bus.in_result[32*k] & bus.in_byte_valid[4*k];
    for (int k = 0; k < NUM_BYTES / 8; k++)
      bits_64[k] = bus.in_result[64*k] & bus.in_byte_valid[8*k];

    // Anything that is not exactly one-hot falls back to the byte size.
    case (osize_q)
      4'b0010: begin elem_bits = bits_16; epb = CNT_W'(NUM_BYTES / 2); end
      4'b0100: begin elem_bits = bits_32; epb = CNT_W'(NUM_BYTES / 4); end
      4'b1000: begin elem_bits = bits_64; epb = CNT_W'(NUM_BYTES / 8); end
      default: begin elem_bits = bits_8;  epb = CNT_W'(NUM_BYTES);     end
    endcase
  end

  always_comb begin
    mask_next = mask_q;
    for (int k = 0; k < NUM_BYTES; k++) begin
      logic [CNT_W-1:0] idx;
      idx = elem_cnt + CNT_W'(k);
      if ((CNT_W'(k) < epb) && (idx < vl_q))
        mask_next[idx[IDX_W-1:0]] = elem_bits[k];
    end
  end

  assign last_beat = (elem_cnt + epb) >= vl_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      osize_q      <= '0;
      vl_q         <= '0;
      elem_cnt     <= '0;
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            osize_q  <= bus.osize;
            vl_q     <= vl_eff;
            elem_cnt <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b1;
            if (vl_eff == '0) begin
              state        <= OUTPUT;
              mask_valid_q <= 1'b1;
            end else begin
              state      <= COLLECT;
              in_ready_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.in_valid && in_ready_q) begin
            mask_q   <= mask_next;
            elem_cnt <= elem_cnt + epb;
            if (last_beat) begin
              state        <= OUTPUT;
              in_ready_q   <= 1'b0;
              mask_valid_q <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (bus.mask_ready) begin
            state        <= IDLE;
            mask_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mask_valid = mask_valid_q;
  assign bus.mask_data  = mask_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_riscv_v_cmp_mask_packer.sv
// Directed bench for the compare-mask packer: reset, each element size,
// vl clamping, zero-length ops, backpressure and mid-operation reset.
module tb_riscv_v_cmp_mask_packer;
  localparam int NB = 16;
  localparam int ME = 128;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  riscv_v_cmp_mask_packer_if #(.NUM_BYTES(NB), .MAX_ELEMS(ME)) bus ();

  riscv_v_cmp_mask_packer #(.NUM_BYTES(NB), .MAX_ELEMS(ME)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [ME-1:0] obs, input logic [ME-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] vl, input logic [3:0] osize);
    bus.start = 1'b1;
    bus.vl    = vl;
    bus.osize = osize;
    tick();
    bus.start = 1'b0;
  endtask

  // lsb[i] is bit 0 of byte i; the upper 7 bits of each byte carry junk.
  task automatic beat(input logic [NB-1:0] lsb, input logic [NB-1:0] bv);
    for (int i = 0; i < NB; i++) bus.in_result[i*8 +: 8] = {7'b1010101, lsb[i]};
    bus.in_byte_valid = bv;
    bus.in_valid      = 1'b1;
    tick();
    bus.in_valid      = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.vl            = '0;
    bus.osize         = '0;
    bus.in_valid      = 1'b0;
    bus.in_result     = '0;
    bus.in_byte_valid = '0;
    bus.mask_ready    = 1'b0;
    tick();
    tick();
    check("reset_busy",       bus.busy, 0);
    check("reset_in_ready",   bus.in_ready, 0);
    check("reset_mask_valid", bus.mask_valid, 0);
    check("reset_mask_data",  bus.mask_data, 0);
    rst_n = 1'b1;

    // 8-bit elements, vl=16, single beat with A5A5 pattern
    start_op(8'd16, 4'b0001);
    check("s1_in_ready",   bus.in_ready, 1);
    check("s1_busy",       bus.busy, 1);
    check("s1_no_valid",   bus.mask_valid, 0);
    beat(16'hA5A5, 16'hFFFF);
    check("s1_mask_valid", bus.mask_valid, 1);
    check("s1_mask_data",  bus.mask_data, 128'hA5A5);
    check("s1_ready_low",  bus.in_ready, 0);
    bus.mask_ready = 1'b1;
    tick();
    bus.mask_ready = 1'b0;
    check("s1_idle_valid", bus.mask_valid, 0);
    check("s1_idle_busy",  bus.busy, 0);
    check("s1_retain",     bus.mask_data, 128'hA5A5);

    // 32-bit elements, vl=10, three beats of all-ones elements
    start_op(8'd10, 4'b0100);
    check("s2_cleared", bus.mask_data, 0);
    beat(16'h1111, 16'hFFFF);
    check("s2_b1_data",  bus.mask_data, 128'hF);
    check("s2_b1_valid", bus.mask_valid, 0);
    beat(16'h1111, 16'hFFFF);
    check("s2_b2_data",  bus.mask_data, 128'hFF);
    check("s2_b2_ready", bus.in_ready, 1);
    beat(16'h1111, 16'hFFFF);
    check("s2_valid", bus.mask_valid, 1);
    check("s2_data",  bus.mask_data, 128'h3FF);
    bus.mask_ready = 1'b1;
    tick();
    bus.mask_ready = 1'b0;

    // vl=0 goes straight to OUTPUT; start coinciding with mask_ready is ignored
    bus.in_valid = 1'b1;
    start_op(8'd0, 4'b0001);
    bus.in_valid = 1'b0;
    check("s3_valid",    bus.mask_valid, 1);
    check("s3_data",     bus.mask_data, 0);
    check("s3_in_ready", bus.in_ready, 0);
    bus.mask_ready = 1'b1;
    start_op(8'd16, 4'b0001);
    bus.mask_ready = 1'b0;
    check("s3_idle_busy",  bus.busy, 0);
    check("s3_idle_valid", bus.mask_valid, 0);
    tick();
    check("s3_start_ignored", bus.busy, 0);
    check("s3_no_ready",      bus.in_ready, 0);

    // vl=200 clamps to 128: exactly 8 beats of 8-bit elements
    start_op(8'd200, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s4_ready_b%0d", i), bus.in_ready, 1);
      check($sformatf("s4_valid_b%0d", i), bus.mask_valid, 0);
      beat(16'hFFFF, 16'hFFFF);
    end
    check("s4_valid",     bus.mask_valid, 1);
    check("s4_ready_low", bus.in_ready, 0);
    check("s4_data",      bus.mask_data, {ME{1'b1}});
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("s4_data_hold", bus.mask_data, {ME{1'b1}});
    bus.mask_ready = 1'b1;
    tick();
    bus.mask_ready = 1'b0;

    // 16-bit elements, byte 0 invalid, then 5 cycles of backpressure
    start_op(8'd8, 4'b0010);
    beat(16'h5555, 16'hFFFE);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s5_valid_c%0d", i), bus.mask_valid, 1);
      check($sformatf("s5_data_c%0d", i),  bus.mask_data, 128'hFE);
      tick();
    end
    bus.mask_ready = 1'b1;
    tick();
    bus.mask_ready = 1'b0;
    check("s5_idle_busy",  bus.busy, 0);
    check("s5_idle_valid", bus.mask_valid, 0);

    // Non-one-hot osize behaves as 8-bit
    start_op(8'd16, 4'b0011);
    beat(16'h00FF, 16'hFFFF);
    check("s5b_valid", bus.mask_valid, 1);
    check("s5b_data",  bus.mask_data, 128'hFF);
    bus.mask_ready = 1'b1;
    tick();
    bus.mask_ready = 1'b0;

    // 64-bit elements, vl=8: reset after 2 of 4 beats
    start_op(8'd8, 4'b1000);
    beat(16'h0101, 16'hFFFF);
    beat(16'h0101, 16'hFFFF);
    check("s6_partial", bus.mask_data, 128'hF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("s6_rst_busy",  bus.busy, 0);
    check("s6_rst_data",  bus.mask_data, 0);
    check("s6_rst_valid", bus.mask_valid, 0);
    check("s6_rst_ready", bus.in_ready, 0);
    tick();
    check("s6_no_pulse", bus.mask_valid, 0);

    // Fresh op: vl=3 of 64-bit, element 3 lands past vl and stays 0
    start_op(8'd3, 4'b1000);
    beat(16'h0001, 16'hFFFF);
    check("s6_f_b1_valid", bus.mask_valid, 0);
    beat(16'h0101, 16'hFFFF);
    check("s6_f_valid", bus.mask_valid, 1);
    check("s6_f_data",  bus.mask_data, 128'h5);
    bus.mask_ready = 1'b1;
    tick();
    bus.mask_ready = 1'b0;
    check("s6_f_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/riscv_v_cmp_mask_packer.md
RISCV_V_CMP_MASK_PACKER -- requirements
Module: riscv_v_cmp_mask_packer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16, giving the data bytes per beat (equal to RISCV_V_NUM_BYTES_DATA).
REQ-002 SHALL have parameter MAX_ELEMS, default 128, giving the packed mask width in bits (must be ≥ NUM_BYTES).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a packing operation.
REQ-006 SHALL have port vl, input, 8, the element count for the operation, sampled with start.
REQ-007 SHALL have port osize, input, 4, the one-hot element size {64,32,16,8}-bit as bits [3:0], sampled with start.
REQ-008 SHALL have port in_valid, input, 1, marking a compare-result beat as present.
REQ-009 SHALL have port in_ready, output, 1, meaning the packer accepts a beat this cycle.
REQ-010 SHALL have port in_result, input, 8*NUM_BYTES, the set-compare result bytes; each element's bit 0 of its least-significant byte is the compare bit.
REQ-011 SHALL have port in_byte_valid, input, NUM_BYTES, the per-byte valid of the beat.
REQ-012 SHALL have port mask_valid, output, 1, marking the packed mask as available.
REQ-013 SHALL have port mask_ready, input, 1, meaning the consumer takes the mask.
REQ-014 SHALL have port mask_data, output, MAX_ELEMS, the packed mask with element i at bit i.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, COLLECT and OUTPUT.
REQ-017 SHALL, in IDLE with start=1, latch osize and the effective vl, clear mask_data and elem_cnt, and move to COLLECT; if the effective vl is 0 it SHALL move directly to OUTPUT instead.
REQ-018 SHALL compute the effective vl as min(vl, MAX_ELEMS).
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL drive in_ready=1 only in COLLECT; a beat is accepted when in_valid && in_ready.
REQ-021 SHALL compute the elements per beat (epb) as NUM_BYTES divided by the latched bytes per element (1, 2, 4 or 8).
REQ-022 SHALL, on an accepted beat, write bit (elem_cnt+k) of mask_data for k in 0..epb-1 only where elem_cnt+k < vl.
- The value written SHALL be in_result[(k*bpe)*8] & in_byte_valid[k*bpe].
REQ-023 SHALL, on an accepted beat, add epb to elem_cnt; elem_cnt SHALL be at least 9 bits wide so it does not wrap at 128+epb.
REQ-024 SHALL move to OUTPUT when an accepted beat makes elem_cnt+epb ≥ vl (final beat); mask_valid SHALL rise in the following cycle (1-cycle latency).
REQ-025 SHALL hold mask bits at index ≥ vl at 0 (tail-zero policy).
REQ-026 SHALL, in OUTPUT, hold mask_valid=1 and mask_data stable until mask_ready=1, then return to IDLE in the next cycle.
REQ-027 SHALL, when mask_ready and start coincide in the OUTPUT cycle, ignore start; a new operation requires start in IDLE.
REQ-028 SHALL make mask_data in IDLE retain the last packed value.
REQ-029 SHALL treat a non-one-hot latched osize as the 8-bit size (epb = NUM_BYTES).

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, go to IDLE and set elem_cnt=0, mask_data=0, mask_valid=0, in_ready=0 and busy=0.
REQ-031 SHALL make reset mid-operation (COLLECT or OUTPUT) abandon the operation with no mask_valid pulse.

Verification
REQ-032 SHALL cover this scenario: osize=8b, vl=16, one beat with bytes 0..15 having bit 0 = 0xA5A5 pattern and all bytes valid -> mask_valid one cycle later with mask_data[15:0]=16'hA5A5 and upper bits 0.
REQ-033 SHALL cover this scenario: osize=32b, vl=10, three beats each with all 4 elements=1 -> mask_data=10'h3FF, bits ≥10 = 0, mask_valid after the third beat.
REQ-034 SHALL cover this scenario: start with vl=0 -> OUTPUT on the next cycle, mask_data=0, in_ready never asserted.
REQ-035 SHALL cover this scenario: vl=200, osize=8b -> exactly 8 beats accepted, mask is 128 bits wide, all ones given all-ones input.
REQ-036 SHALL cover this scenario: backpressure, with mask_ready=0 for 5 cycles -> mask_valid and mask_data stable throughout, then IDLE one cycle after mask_ready=1; in_valid with in_byte_valid[0]=0 writes a 0 bit.
REQ-037 SHALL cover this scenario: rst_n=0 after 2 of 4 beats -> IDLE, mask_data=0, and no mask_valid; a fresh start then completes normally.
